// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the three-digit 7-segment scan controller.
// Imported by the decoder sub-module and the top level.
package disp_scan_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_DASH   = 7'h3F;
    localparam int         NUM_DIGITS = 3;

    typedef struct packed {
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic       dot;
        logic       blank_lz;
    } shadow_t;

    // Active-low anode vector with only the selected digit enabled.
    function automatic logic [2:0] anode_for(input logic [1:0] ptr);
        logic [2:0] onehot;
        onehot = 3'b001 << ptr;
        return ~onehot;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit-set update handshake between the BCD decoder (master) and the
// scan controller (slave).
interface seg_scan_ctrl_if;

    logic [3:0] sg1;
    logic [3:0] sg2;
    logic [3:0] sg3;
    logic       dot;
    logic       blank_lz;
    logic       upd_valid;
    logic       upd_ready;

    modport master (
        output sg1, sg2, sg3, dot, blank_lz, upd_valid,
        input  upd_ready
    );

    modport slave (
        input  sg1, sg2, sg3, dot, blank_lz, upd_valid,
        output upd_ready
    );

endinterface

// File: rtl/seg_scan_ctrl_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment map ({g,f,e,d,c,b,a}).
// Non-decimal codes show a dash; blank overrides everything.
module bcd_to_seg7
    import disp_scan_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_DASH;
        if (blank) begin
            seg_n = SEG_BLANK;
        end else begin
            case (bcd)
                4'd0:    seg_n = 7'h40;
                4'd1:    seg_n = 7'h79;
                4'd2:    seg_n = 7'h24;
                4'd3:    seg_n = 7'h30;
                4'd4:    seg_n = 7'h19;
                4'd5:    seg_n = 7'h12;
                4'd6:    seg_n = 7'h02;
                4'd7:    seg_n = 7'h78;
                4'd8:    seg_n = 7'h00;
                4'd9:    seg_n = 7'h10;
                default: seg_n = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of three BCD digits plus a decimal point onto one
// active-low 7-segment bus, with anti-ghost blanking and frame-aligned updates.
module seg_scan_ctrl
    import disp_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int GHOST_CYC = 500
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  upd,
    output logic [6:0]      seg_n,
    output logic            dp_n,
    output logic [2:0]      an_n,
    output logic            frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] GHOST_LAST = CNT_W'(GHOST_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [1:0]       PTR_LAST   = 2'(NUM_DIGITS - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    shadow_t          shadow_q, shadow_d;

    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic [2:0] an_q, an_d;
    logic       tick_q, tick_d;
    logic       ready_q, ready_d;

    logic [3:0] cur_digit;
    logic       lz0, lz1;
    logic       cur_blank;
    logic [6:0] dec_seg;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        shadow_d = shadow_q;
        case (state_q)
            LOAD: begin
                state_d = BLANK;
                ptr_d   = 2'd0;
                cnt_d   = '0;
                if (upd.upd_valid && ready_q) begin
                    shadow_d = '{d0: upd.sg1, d1: upd.sg2, d2: upd.sg3,
                                 dot: upd.dot, blank_lz: upd.blank_lz};
                end
            end
            BLANK: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GHOST_LAST) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == SLOT_LAST) begin
                    cnt_d = '0;
                    if (ptr_q == PTR_LAST) begin
                        state_d = LOAD;
                    end else begin
                        state_d = BLANK;
                        ptr_d   = ptr_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
                ptr_d   = 2'd0;
            end
        endcase
    end

    // Leading-zero blanking ripples left to right; the dot keeps digit 0 visible.
    always_comb begin
        lz0       = shadow_d.blank_lz && (shadow_d.d0 == 4'd0) && !shadow_d.dot;
        lz1       = lz0 && (shadow_d.d1 == 4'd0);
        cur_digit = shadow_d.d2;
        cur_blank = 1'b0;
        case (ptr_d)
            2'd0: begin
                cur_digit = shadow_d.d0;
                cur_blank = lz0;
            end
            2'd1: begin
                cur_digit = shadow_d.d1;
                cur_blank = lz1;
            end
            default: begin
                cur_digit = shadow_d.d2;
                cur_blank = 1'b0;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd   (cur_digit),
        .blank (cur_blank),
        .seg_n (dec_seg)
    );

    // Pins are decoded from the next state so each register lines up with state_q.
    always_comb begin
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        an_d    = 3'b111;
        tick_d  = 1'b0;
        ready_d = (state_d == LOAD);
        if (state_d == DRIVE) begin
            seg_d  = dec_seg;
            an_d   = anode_for(ptr_d);
            dp_d   = (ptr_d == 2'd0) ? ~shadow_d.dot : 1'b1;
            tick_d = (ptr_d == PTR_LAST) && (cnt_d == SLOT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BLANK;
            cnt_q    <= '0;
            ptr_q    <= 2'd0;
            shadow_q <= '0;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            an_q     <= 3'b111;
            tick_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            tick_q   <= tick_d;
            ready_q  <= ready_d;
        end
    end

    assign seg_n         = seg_q;
    assign dp_n          = dp_q;
    assign an_n          = an_q;
    assign frame_tick    = tick_q;
    assign upd.upd_ready = ready_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: frame-position reference model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_seg_scan_ctrl;

    localparam int S     = 8;
    localparam int G     = 2;
    localparam int FRAME = 1 + 3 * S;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seg_scan_ctrl_if bus ();
    logic [6:0] seg_n;
    logic       dp_n;
    logic [2:0] an_n;
    logic       frame_tick;

    seg_scan_ctrl #(.SCAN_DIV(S), .GHOST_CYC(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd        (bus),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_tick = -1;

    logic [6:0] seg_tab [16];
    logic [3:0] m_dig [3];
    logic       m_dot;
    logic       m_blz;

    // Cycle index since reset release; cycle 0 is the one containing release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h required %0h", name, cyc, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                                 input logic d, input logic lz, input logic v);
        bus.sg1       = a;
        bus.sg2       = b;
        bus.sg3       = c;
        bus.dot       = d;
        bus.blank_lz  = lz;
        bus.upd_valid = v;
    endtask

    // Expected pins from the position of this cycle inside the 25-cycle frame.
    task automatic model_outputs(output logic [6:0] e_seg, output logic e_dp, output logic [2:0] e_an,
                                 output logic e_tick, output logic e_rdy);
        int phase, k, dig, off;
        logic z0, blanked;
        logic [2:0] one;
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 3'b111; e_tick = 1'b0; e_rdy = 1'b0;
        phase = (cyc + 1) % FRAME;
        if (phase == 0) begin
            e_rdy = 1'b1;
        end else begin
            k   = phase - 1;
            dig = k / S;
            off = k % S;
            if (off >= G) begin
                one     = 3'b001 << dig;
                e_an    = ~one;
                z0      = m_blz && (m_dig[0] == 4'd0) && !m_dot;
                blanked = (dig == 0 && z0) || (dig == 1 && z0 && m_dig[1] == 4'd0);
                e_seg   = blanked ? 7'h7F : seg_tab[m_dig[dig]];
                if (dig == 0) e_dp = ~m_dot;
                e_tick  = (dig == 2) && (off == S - 1);
            end
        end
    endtask

    always @(negedge clk) begin
        logic [6:0] e_seg;
        logic e_dp, e_tick, e_rdy;
        logic [2:0] e_an;
        if (!rst_n) begin
            checkOutput("rst_seg", seg_n, 7'h7F);
            checkOutput("rst_an", an_n, 3'b111);
            checkOutput("rst_dp", dp_n, 1'b1);
            checkOutput("rst_tick", frame_tick, 1'b0);
            checkOutput("rst_ready", bus.upd_ready, 1'b0);
            for (int i = 0; i < 3; i++) m_dig[i] = 4'd0;
            m_dot = 1'b0;
            m_blz = 1'b0;
            last_tick = -1;
        end else begin
            model_outputs(e_seg, e_dp, e_an, e_tick, e_rdy);
            checkOutput("seg_n", seg_n, e_seg);
            checkOutput("dp_n", dp_n, e_dp);
            checkOutput("an_n", an_n, e_an);
            checkOutput("frame_tick", frame_tick, e_tick);
            checkOutput("upd_ready", bus.upd_ready, e_rdy);
            checkOutput("one_anode", ($countones(~an_n) <= 1), 1);
            if (frame_tick === 1'b1) begin
                if (last_tick >= 0) checkOutput("tick_period", cyc - last_tick, FRAME);
                last_tick = cyc;
            end
            if (((cyc + 1) % FRAME) == 0 && bus.upd_valid) begin
                m_dig[0] = bus.sg1;
                m_dig[1] = bus.sg2;
                m_dig[2] = bus.sg3;
                m_dot    = bus.dot;
                m_blz    = bus.blank_lz;
            end
        end
    end

    task automatic wait_to(input int n);
        int guard = 0;
        while (cyc < n && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_to timeout: got cycle %0d required %0d", cyc, n);
        end
    endtask

    task automatic check_slot(input string name, input logic [2:0] an, input logic [6:0] seg, input logic dp);
        checkOutput({name, "_an"}, an_n, an);
        checkOutput({name, "_seg"}, seg_n, seg);
        checkOutput({name, "_dp"}, dp_n, dp);
    endtask

    initial begin
        int guard;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        applyStimulus(4'd0, 4'd7, 4'd5, 1'b1, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_slot("reset", 3'b111, 7'h7F, 1'b1);
        rst_n = 1'b1;

        // First frame shows shadow zeros; first LOAD at cycle 24.
        wait_to(2);
        check_slot("zeros_d0", 3'b110, 7'h40, 1'b1);
        wait_to(23);
        checkOutput("tick_first", frame_tick, 1'b1);
        checkOutput("ready_pre", bus.upd_ready, 1'b0);
        wait_to(24);
        checkOutput("ready_first", bus.upd_ready, 1'b1);
        wait_to(25);
        bus.upd_valid = 1'b0;
        checkOutput("ghost_an", an_n, 3'b111);
        wait_to(27);
        check_slot("d0_075", 3'b110, 7'h40, 1'b0);
        wait_to(36);
        check_slot("d1_075", 3'b101, 7'h78, 1'b1);
        wait_to(45);
        check_slot("d2_075", 3'b011, 7'h12, 1'b1);

        // One-cycle offer mid-DRIVE must be ignored.
        wait_to(55);
        applyStimulus(4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b1);
        wait_to(56);
        bus.upd_valid = 1'b0;
        wait_to(77);
        check_slot("pulse_ignored", 3'b110, 7'h40, 1'b0);

        // Offer held through LOAD with leading-zero blanking.
        wait_to(95);
        applyStimulus(4'd0, 4'd0, 4'd5, 1'b0, 1'b1, 1'b1);
        wait_to(100);
        bus.upd_valid = 1'b0;
        wait_to(102);
        check_slot("lz_d0", 3'b110, 7'h7F, 1'b1);
        wait_to(111);
        check_slot("lz_d1", 3'b101, 7'h7F, 1'b1);
        wait_to(120);
        check_slot("lz_d2", 3'b011, 7'h12, 1'b1);

        wait_to(121);
        applyStimulus(4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b1);
        wait_to(125);
        bus.upd_valid = 1'b0;
        wait_to(127);
        check_slot("lzdot_d0", 3'b110, 7'h40, 1'b0);
        wait_to(136);
        check_slot("lzdot_d1", 3'b101, 7'h40, 1'b1);

        wait_to(140);
        applyStimulus(4'd3, 4'hC, 4'd9, 1'b0, 1'b0, 1'b1);
        wait_to(150);
        bus.upd_valid = 1'b0;
        wait_to(152);
        check_slot("dash_d0", 3'b110, 7'h30, 1'b1);
        wait_to(161);
        check_slot("dash_d1", 3'b101, 7'h3F, 1'b1);
        wait_to(170);
        check_slot("dash_d2", 3'b011, 7'h10, 1'b1);

        // Randomized offers, checked by the per-cycle model.
        for (int i = 0; i < 250; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
            @(posedge clk);
            #1;
        end
        bus.upd_valid = 1'b0;

        // Free run: tick period, single anode and ghost gaps checked per cycle.
        repeat (5 * FRAME) begin
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of digit 1 DRIVE.
        guard = 0;
        while (((cyc + 1) % FRAME) != 13 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("pre_reset_an", an_n, 3'b101);
        applyStimulus(4'd9, 4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_slot("async_rst", 3'b111, 7'h7F, 1'b1);
        checkOutput("async_rst_tick", frame_tick, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_to(2);
        check_slot("post_rst_zero", 3'b110, 7'h40, 1'b1);
        wait_to(23);
        checkOutput("post_rst_ready_pre", bus.upd_ready, 1'b0);
        wait_to(24);
        checkOutput("post_rst_ready", bus.upd_ready, 1'b1);
        wait_to(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan controller that time-multiplexes three BCD digits plus a decimal point onto one shared active-low 7-segment bus with per-digit anode enables. It sits downstream of the fraction-to-BCD decoder (digits SG1/SG2/SG3, dot) and drives the board display. New digit sets are accepted through a valid/ready handshake, only at frame boundaries, so the display never shows a torn frame. The block adds ghost-suppression blanking between digits and optional leading-zero blanking.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot; must be at least GHOST_CYC+1.
GHOST_CYC, 500, cycles at the start of each slot with all anodes off; must be at least 1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sg1  in  4  BCD digit, most significant (digit 0, left)
sg2  in  4  BCD digit 1
sg3  in  4  BCD digit 2, least significant (right)
dot  in  1  decimal point shown after digit 0
blank_lz  in  1  leading-zero blanking enable
upd_valid  in  1  new digit set offered
upd_ready  out  1  block accepts the offered set this cycle
seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
dp_n  out  1  decimal point, active-low
an_n  out  3  anode enables, active-low; bit i drives digit i
frame_tick  out  1  one-cycle pulse at the end of each scan frame

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low; assertion takes effect immediately, including mid-frame.
- Reset values: an_n=3'b111, seg_n=7'h7F, dp_n=1, upd_ready=0, frame_tick=0.
- Reset values, internal: shadow digits all 0, shadow dot=0, shadow blank_lz=0, slot counter=0, digit pointer=0, state=BLANK.
- FSM states:
  - LOAD: 1 cycle, all anodes off, upd_ready=1.
  - BLANK: GHOST_CYC cycles, all anodes off.
  - DRIVE: SCAN_DIV-GHOST_CYC cycles, the anode for the current digit is on.
- Transitions:
  - LOAD -> BLANK with ptr=0.
  - BLANK -> DRIVE when the slot counter reaches GHOST_CYC-1.
  - DRIVE -> BLANK with ptr+1 when the counter reaches SCAN_DIV-1 and ptr<2.
  - DRIVE -> LOAD when the counter reaches SCAN_DIV-1 and ptr=2.
  - The counter clears at every slot end.
- Frame length is 1+3*SCAN_DIV cycles. The first LOAD occurs 3*SCAN_DIV cycles after reset release, so shadow zeros are displayed until then.
- frame_tick is 1 exactly in the last DRIVE cycle of digit 2.
- Handshake:
  - upd_ready = (state==LOAD).
  - On upd_valid && upd_ready, sg1..sg3, dot and blank_lz are captured into the shadow registers.
  - Without a transfer, the shadow registers hold their values.
  - The upstream may hold upd_valid high indefinitely; the block never waits on upd_valid.
- Display path: in BLANK, DRIVE and LOAD, seg_n, dp_n and an_n are registered functions of state, ptr and shadow only. There is no combinational path from inputs to pins.
- BLANK and LOAD outputs: seg_n=7F, dp_n=1, an_n=111.
- DRIVE outputs: an_n has bit ptr low and the other bits high.
- seg_n encoding:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10.
  - Any code 10..15 shows a dash, 3F.
- dp_n = ~shadow dot when ptr=0, else 1.
- Leading-zero blanking, when the shadow blank_lz=1:
  - Digit 0 is blanked (seg_n=7F) if d0==0 and dot==0.
  - Digit 1 is blanked if digit 0 is blanked and d1==0.
  - Digit 2 is never blanked.
  - A blanked digit still has its anode low.
- The counter width is the minimum needed to hold SCAN_DIV-1. There is no wrap other than the slot-end clear.

Decomposition:
- Package disp_scan_pkg holds:
  - the state enum {LOAD, BLANK, DRIVE};
  - segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F;
  - the NUM_DIGITS=3 constant.
- One sub-module, bcd_to_seg7: combinational map from 4-bit BCD plus a blank flag to 7-bit active-low segments.

Test Plan:
All scenarios use SCAN_DIV=8 and GHOST_CYC=2, giving a frame of 25 cycles.
- Reset release with sg=0,7,5, dot=1, upd_valid held 1 -> upd_ready first high at cycle 24; capture takes place there.
- Next frame after that capture -> digit0 DRIVE with an_n=110, seg_n=40, dp_n=0; digit1 an_n=101, seg_n=78; digit2 an_n=011, seg_n=12.
- upd_valid pulsed for 1 cycle mid-DRIVE with a new set -> not captured; the display is unchanged.
- Same set held through LOAD -> captured; the new values appear from the following BLANK and DRIVE.
- blank_lz=1 with sg=0,0,5, dot=0 -> digits 0 and 1 show seg_n=7F with anodes active; digit 2 shows 12.
- Same with dot=1 -> digit 0 shows 40 with dp_n=0.
- sg2=4'hC -> digit 1 seg_n=3F; all other digits unaffected.
- rst_n dropped mid-DRIVE of digit 1 -> same-cycle an_n=111, seg_n=7F, frame_tick=0; after release the shadows are 0 and the first upd_ready comes 24 cycles later.
- Free run for 5 frames -> frame_tick pulses exactly every 25 cycles.
- Free run for 5 frames -> no cycle has more than one an_n bit low.
- Free run for 5 frames -> an_n=111 for 2 cycles before each digit.
